// File: rtl/drum_hit_tally_if.sv
// Pad-hit inputs and display outputs of drum_hit_tally, grouped as one bundle.
// The master side drives hit/clear/freeze. The slave side (the counter) returns data/overflow.
interface drum_hit_tally_if;
  logic [3:0]  hit;
  logic        clear;
  logic        freeze;
  logic [63:0] data;
  logic [3:0]  overflow;

  modport master (
    output hit,
    output clear,
    output freeze,
    input  data,
    input  overflow
  );

  modport slave (
    input  hit,
    input  clear,
    input  freeze,
    output data,
    output overflow
  );
endinterface

// File: rtl/drum_hit_tally.sv
// Four-pad drum-hit tally: BCD counters per pad, snapshotted into a 64-bit display word.
// Optional per-pad retrigger lockout is enabled by defining TALLY_LOCKOUT_EN.
module drum_hit_tally #(
  parameter int LOCKOUT_CYCLES = 270000,
  parameter int SNAP_DIV       = 27000
) (
  input  logic             clock_27mhz,
  input  logic             reset,
  drum_hit_tally_if.slave  tally
);

  localparam logic [14:0] SNAP_LAST = 15'(SNAP_DIV - 1);
  localparam logic [15:0] BCD_MAX   = 16'h9999;

  if (SNAP_DIV < 2 || LOCKOUT_CYCLES < 1) begin : g_param_check
    $error("drum_hit_tally: SNAP_DIV must be >= 2 and LOCKOUT_CYCLES >= 1");
  end

  logic [3:0]  hit_q;
  logic [3:0]  rise;
  logic [3:0]  accept;
  logic [3:0]  ovf_set;
  logic [15:0] cnt      [4];
  logic [15:0] cnt_next [4];
  logic [14:0] snap;
  logic        tick;

  function automatic logic [15:0] bcd_inc(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (value[4*d +: 4] == 4'd9) begin
          result[4*d +: 4] = 4'd0;
        end else begin
          result[4*d +: 4] = value[4*d +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return result;
  endfunction

  assign rise = tally.hit & ~hit_q;
  assign tick = (snap == SNAP_LAST);

  // hit_q resets high so a line already held at release is not a rise
  always_ff @(posedge clock_27mhz) begin
    if (reset) hit_q <= 4'b1111;
    else       hit_q <= tally.hit;
  end

`ifdef TALLY_LOCKOUT_EN
  localparam logic [18:0] LOCK_LOAD = 19'(LOCKOUT_CYCLES - 1);

  logic [18:0] lock [4];

  always_comb begin
    accept = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      accept[i] = rise[i] & (lock[i] == 19'd0);
    end
  end

  // rejected rises leave lock untouched; only accepted ones reload it
  always_ff @(posedge clock_27mhz) begin
    if (reset || tally.clear) begin
      for (int i = 0; i < 4; i++) lock[i] <= 19'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept[i])              lock[i] <= LOCK_LOAD;
        else if (lock[i] != 19'd0)  lock[i] <= lock[i] - 19'd1;
      end
    end
  end
`else
  assign accept = rise;
`endif

  always_comb begin
    ovf_set = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = cnt[i];
      if (accept[i]) begin
        if (cnt[i] == BCD_MAX) ovf_set[i]  = 1'b1;
        else                   cnt_next[i] = bcd_inc(cnt[i]);
      end
    end
  end

  // clear wins over any coincident rise, so that rise is simply dropped
  always_ff @(posedge clock_27mhz) begin
    if (reset || tally.clear) begin
      for (int i = 0; i < 4; i++) cnt[i] <= 16'h0000;
      tally.overflow <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_next[i];
      tally.overflow <= tally.overflow | ovf_set;
    end
  end

  always_ff @(posedge clock_27mhz) begin
    if (reset)     snap <= 15'd0;
    else if (tick) snap <= 15'd0;
    else           snap <= snap + 15'd1;
  end

  // snapshot takes cnt_next so an increment on the tick cycle is shown at once
  always_ff @(posedge clock_27mhz) begin
    if (reset || tally.clear) begin
      tally.data <= 64'h0;
    end else if (tick && !tally.freeze) begin
      tally.data <= {cnt_next[3], cnt_next[2], cnt_next[1], cnt_next[0]};
    end
  end

endmodule

// File: tb/tb_drum_hit_tally.sv
// Directed bench for drum_hit_tally with LOCKOUT_CYCLES=4, SNAP_DIV=2.
// Expected pad-1 toggle count depends on TALLY_LOCKOUT_EN.
module tb_drum_hit_tally;

  logic clock_27mhz;
  logic reset;
  int   checks;
  int   errors;

  drum_hit_tally_if tally ();

  drum_hit_tally #(
    .LOCKOUT_CYCLES (4),
    .SNAP_DIV       (2)
  ) dut (
    .clock_27mhz (clock_27mhz),
    .reset       (reset),
    .tally       (tally.slave)
  );

  // Pad 1 toggles every cycle for 12 cycles: rises at 0,2,4,6,8,10; lockout of 4 keeps 0,4,8
`ifdef TALLY_LOCKOUT_EN
  localparam logic [15:0] PAD1_EXP = 16'h0003;
`else
  localparam logic [15:0] PAD1_EXP = 16'h0006;
`endif

  initial clock_27mhz = 1'b0;
  always #5 clock_27mhz = ~clock_27mhz;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_27mhz);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int count, input int gap);
    repeat (count) begin
      tally.hit = mask;
      step(1);
      tally.hit = 4'b0000;
      step(gap - 1);
    end
  endtask

  logic [63:0] expected_word;
  logic [63:0] frozen_word;

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    tally.hit    = 4'b1111;
    tally.clear  = 1'b0;
    tally.freeze = 1'b0;
    step(3);
    checkOutput("reset_data", tally.data, 64'h0);
    checkOutput("reset_overflow", 64'(tally.overflow), 64'h0);

    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(2);
      checkOutput("held_high_data", tally.data, 64'h0);
    end
    tally.hit = 4'b0000;
    step(3);
    checkOutput("falling_edge_data", tally.data, 64'h0);

    applyStimulus(4'b0001, 5, 10);
    step(3);
    checkOutput("pad0_five", tally.data, 64'h0000_0000_0000_0005);

    applyStimulus(4'b0100, 12, 10);
    step(3);
    checkOutput("pad2_slice", 64'(tally.data[47:32]), 64'h0012);
    checkOutput("pad2_word", tally.data, 64'h0000_0012_0000_0005);

    for (int c = 0; c < 12; c++) begin
      tally.hit = (c % 2 == 0) ? 4'b0010 : 4'b0000;
      step(1);
    end
    tally.hit = 4'b0000;
    step(5);
    checkOutput("pad1_toggle", 64'(tally.data[31:16]), 64'(PAD1_EXP));

    applyStimulus(4'b1000, 9998, 5);
    step(3);
    checkOutput("pad3_preload", 64'(tally.data[63:48]), 64'h9998);
    checkOutput("pad3_preload_ovf", 64'(tally.overflow), 64'h0);
    applyStimulus(4'b1000, 3, 5);
    step(3);
    checkOutput("pad3_saturate", 64'(tally.data[63:48]), 64'h9999);
    checkOutput("pad3_overflow", 64'(tally.overflow), 64'b1000);
    expected_word = {16'h9999, 16'h0012, PAD1_EXP, 16'h0005};
    checkOutput("full_word", tally.data, expected_word);

    frozen_word  = expected_word;
    tally.freeze = 1'b1;
    step(1);
    applyStimulus(4'b0001, 3, 5);
    step(3);
    checkOutput("frozen_data", tally.data, frozen_word);
    tally.freeze = 1'b0;
    step(2);
    checkOutput("unfrozen_pad0", 64'(tally.data[15:0]), 64'h0008);

    tally.freeze = 1'b1;
    tally.hit    = 4'b1111;
    tally.clear  = 1'b1;
    step(1);
    tally.clear  = 1'b0;
    checkOutput("clear_data", tally.data, 64'h0);
    checkOutput("clear_overflow", 64'(tally.overflow), 64'h0);
    tally.freeze = 1'b0;
    step(4);
    checkOutput("clear_rise_dropped", tally.data, 64'h0);
    tally.hit = 4'b0000;
    step(2);

    applyStimulus(4'b0001, 2, 5);
    step(3);
    checkOutput("post_clear_count", tally.data, 64'h2);
    reset = 1'b1;
    step(1);
    checkOutput("midrun_reset_data", tally.data, 64'h0);
    reset = 1'b0;
    step(3);
    checkOutput("after_reset_data", tally.data, 64'h0);
    applyStimulus(4'b0001, 1, 5);
    step(3);
    checkOutput("after_reset_count", tally.data, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
